waveform_buffer_reader: RTL and testbench

- Readout-side counterpart of waveform acquisition.
- Pops one waveform header from the waveform buffer, then reads that waveform's samples, and serializes both into a 32-bit valid/ready word stream with end-of-packet marking.
- Drives the buffer's hdr_rdreq / wvb_rdreq / wvb_rddone handshake.
- Sits between a waveform buffer and the readout FIFO/DMA.

---
 rtl/waveform_buffer_reader.sv | 176 +++++++++++++++++
 tb/tb_waveform_buffer_reader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_buffer_reader.sv
// Waveform buffer readout: pops one header, streams its samples, and packs
// both into a 32-bit valid/ready word stream with end-of-packet marking.
module waveform_buffer_reader #(
    parameter int unsigned P_DATA_WIDTH         = 28,
    parameter int unsigned P_HDR_WIDTH          = 87,
    parameter int unsigned P_LTC_WIDTH          = 48,
    parameter int unsigned P_ADR_WIDTH          = 15,
    parameter int unsigned P_N_WVF_IN_BUF_WIDTH = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [P_HDR_WIDTH-1:0]          wvb_hdr_data_out,
    input  logic                            wvb_hdr_empty,
    input  logic [P_N_WVF_IN_BUF_WIDTH-1:0] wvb_n_wvf_in_buf,
    input  logic [P_DATA_WIDTH-1:0]         wvb_data_out,
    output logic                            wvb_hdr_rdreq,
    output logic                            wvb_wvb_rdreq,
    output logic                            wvb_wvb_rddone,
    output logic [31:0]                     dout,
    output logic                            dout_valid,
    output logic                            dout_last,
    input  logic                            dout_ready,
    output logic                            busy,
    output logic [15:0]                     n_wvf_sent
);

    typedef enum logic [2:0] {StIdle, StHdr0, StHdr1, StHdr2, StData, StDone} state_t;

    state_t state_q, state_d;

    logic [P_LTC_WIDTH-1:0]  ltc_q;
    logic [1:0]              trig_q;
    logic                    cnst_q;
    logic [P_ADR_WIDTH-1:0]  n_samp_q;
    logic [15:0]             req_cnt_q;
    logic [15:0]             sent_cnt_q;
    logic                    inflight_q;
    logic [P_DATA_WIDTH-1:0] skid_q [2];
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              count_q;
    logic                    hdr_rdreq_q;
    logic [15:0]             n_wvf_sent_q;

    logic                    start;
    logic [P_ADR_WIDTH-1:0]  hdr_start;
    logic [P_ADR_WIDTH-1:0]  hdr_stop;
    logic [15:0]             limit;
    logic                    pop;
    logic                    last_samp;
    logic [2:0]              occ;
    logic                    rdreq;
    logic                    unused_inputs;

    assign hdr_start = wvb_hdr_data_out[38:24];
    assign hdr_stop  = wvb_hdr_data_out[23:9];
    assign start     = (state_q == StIdle) && en && !wvb_hdr_empty;

    // A count of zero stands for a full 32768-sample waveform.
    assign limit     = {n_samp_q == '0, n_samp_q};
    assign pop       = (state_q == StData) && (count_q != 2'd0) && dout_ready;
    assign last_samp = (sent_cnt_q == limit - 16'd1);

    // Credit counts the slot freed by this cycle's pop so a full-rate stream is sustained.
    assign occ   = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
    assign rdreq = ((state_q == StHdr1) || (state_q == StHdr2) || (state_q == StData))
                   && (occ < 3'd2) && (req_cnt_q < limit);

    assign unused_inputs = ^{wvb_n_wvf_in_buf, wvb_hdr_data_out[5:0]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StHdr0;
            StHdr0:  if (dout_ready) state_d = StHdr1;
            StHdr1:  if (dout_ready) state_d = StHdr2;
            StHdr2:  if (dout_ready) state_d = StData;
            StData:  if (pop && last_samp) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode: word mux, handshake strobes and status.
    always_comb begin
        dout           = 32'h0;
        dout_valid     = 1'b0;
        dout_last      = 1'b0;
        wvb_wvb_rddone = 1'b0;
        unique case (state_q)
            StHdr0: begin
                dout_valid = 1'b1;
                dout       = {8'hA5, 5'b0, cnst_q, trig_q, 1'b0, n_samp_q};
            end
            StHdr1: begin
                dout_valid = 1'b1;
                dout       = {16'h0, ltc_q[47:32]};
            end
            StHdr2: begin
                dout_valid = 1'b1;
                dout       = ltc_q[31:0];
            end
            StData: begin
                dout_valid = (count_q != 2'd0);
                dout_last  = (count_q != 2'd0) && last_samp;
                dout       = {{(32 - P_DATA_WIDTH){1'b0}}, skid_q[rd_ptr_q]};
            end
            StDone:  wvb_wvb_rddone = 1'b1;
            default: ;
        endcase
        wvb_wvb_rdreq = rdreq;
        wvb_hdr_rdreq = hdr_rdreq_q;
        busy          = (state_q != StIdle);
        n_wvf_sent    = n_wvf_sent_q;
    end

    // Header latch, request/transfer counters and the completion counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ltc_q        <= '0;
            trig_q       <= '0;
            cnst_q       <= 1'b0;
            n_samp_q     <= '0;
            req_cnt_q    <= '0;
            sent_cnt_q   <= '0;
            hdr_rdreq_q  <= 1'b0;
            n_wvf_sent_q <= '0;
        end else begin
            hdr_rdreq_q <= start;
            if (start) begin
                ltc_q      <= wvb_hdr_data_out[86:39];
                trig_q     <= wvb_hdr_data_out[8:7];
                cnst_q     <= wvb_hdr_data_out[6];
                n_samp_q   <= hdr_stop - hdr_start + 15'd1;
                req_cnt_q  <= '0;
                sent_cnt_q <= '0;
            end else begin
                if (rdreq) req_cnt_q <= req_cnt_q + 16'd1;
                if (pop)   sent_cnt_q <= sent_cnt_q + 16'd1;
            end
            if (state_q == StDone) n_wvf_sent_q <= n_wvf_sent_q + 16'd1;
        end
    end

    // Two-entry skid FIFO absorbing the one-cycle buffer read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            skid_q[0]  <= '0;
            skid_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            inflight_q <= rdreq;
            if (inflight_q) begin
                skid_q[wr_ptr_q] <= wvb_data_out;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_waveform_buffer_reader.sv
// Directed bench for waveform_buffer_reader with a behavioural buffer model
// and a scoreboard of expected output words.
module tb_waveform_buffer_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [86:0] wvb_hdr_data_out;
    logic        wvb_hdr_empty;
    logic [9:0]  wvb_n_wvf_in_buf;
    logic [27:0] wvb_data_out;
    logic        wvb_hdr_rdreq;
    logic        wvb_wvb_rdreq;
    logic        wvb_wvb_rddone;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_last;
    logic        dout_ready;
    logic        busy;
    logic [15:0] n_wvf_sent;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    waveform_buffer_reader dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .wvb_hdr_data_out (wvb_hdr_data_out),
        .wvb_hdr_empty    (wvb_hdr_empty),
        .wvb_n_wvf_in_buf (wvb_n_wvf_in_buf),
        .wvb_data_out     (wvb_data_out),
        .wvb_hdr_rdreq    (wvb_hdr_rdreq),
        .wvb_wvb_rdreq    (wvb_wvb_rdreq),
        .wvb_wvb_rddone   (wvb_wvb_rddone),
        .dout             (dout),
        .dout_valid       (dout_valid),
        .dout_last        (dout_last),
        .dout_ready       (dout_ready),
        .busy             (busy),
        .n_wvf_sent       (n_wvf_sent)
    );

    // Header FIFO model (first-word-fall-through) and sample memory model.
    logic [86:0] hdr_mem   [0:63];
    logic [15:0] nsamp_mem [0:63];
    int          hw = 0;
    int          hr = 0;
    logic [14:0] rd_addr;
    logic [12:0] tag_cur;
    logic [32:0] exp_q [$];

    assign wvb_hdr_empty    = (hw == hr);
    assign wvb_hdr_data_out = hdr_mem[hr[5:0]];
    assign wvb_n_wvf_in_buf = 10'(hw - hr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wvb_data_out <= '0;
        end else begin
            if (wvb_hdr_rdreq) begin
                rd_addr <= hdr_mem[hr[5:0]][38:24];
                tag_cur <= 13'(hr);
                hr      <= hr + 1;
            end
            if (wvb_wvb_rdreq) begin
                wvb_data_out <= {tag_cur, rd_addr};
                rd_addr      <= rd_addr + 15'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue a header in the buffer model and push its expected packet.
    task automatic push_hdr(input logic [47:0] ltc, input logic [14:0] start,
                            input logic [14:0] stop, input logic [1:0] trig, input logic cnst);
        logic [14:0] n;
        logic [14:0] a;
        int          nn;
        n  = stop - start + 15'd1;
        nn = (n == 15'd0) ? 32768 : int'(n);
        exp_q.push_back({1'b0, 8'hA5, 5'b0, cnst, trig, 1'b0, n});
        exp_q.push_back({1'b0, 16'h0, ltc[47:32]});
        exp_q.push_back({1'b0, ltc[31:0]});
        for (int i = 0; i < nn; i++) begin
            a = start + 15'(i);
            exp_q.push_back({(i == nn - 1), 4'h0, 13'(hw), a});
        end
        nsamp_mem[hw[5:0]] = 16'(nn);
        hdr_mem[hw[5:0]]   = {ltc, start, stop, trig, cnst, 6'h15};
        hw++;
    endtask

    // Output monitor: scoreboard compare, stall stability, credit and ordering.
    int          done_cnt = 0;
    int          pop_cnt = 0;
    int          rdreq_cnt = 0;
    int          aborted = 0;
    int          req_in_pkt = 0;
    int          samp_in_pkt = 0;
    int          word_in_pkt = 0;
    int          cur_n = 0;
    bit          stall_prev = 1'b0;
    logic [32:0] word_prev;
    logic [32:0] e;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) check("stall_stable", {dout_valid, dout_last, dout}, {1'b1, word_prev});
            if (wvb_hdr_rdreq) begin
                check("hdr_after_done", pop_cnt, done_cnt + aborted);
                pop_cnt++;
                cur_n       = int'(nsamp_mem[hr[5:0]]);
                req_in_pkt  = 0;
                samp_in_pkt = 0;
                word_in_pkt = 0;
            end
            if (dout_valid && dout_ready) begin
                checks++;
                assert (exp_q.size() != 0)
                else begin
                    failures++;
                    $error("FAIL unexpected_word observed=%0h expected=none", dout);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("word", {dout_last, dout}, e);
                end
                word_in_pkt++;
                if (word_in_pkt > 3) samp_in_pkt++;
            end
            if (wvb_wvb_rdreq) begin
                req_in_pkt++;
                rdreq_cnt++;
                check("outstanding_le2", (req_in_pkt - samp_in_pkt <= 2), 1);
            end
            if (wvb_wvb_rddone) begin
                done_cnt++;
                check("reqs_per_pkt", req_in_pkt, cur_n);
                check("samps_per_pkt", samp_in_pkt, cur_n);
            end
            stall_prev = dout_valid && !dout_ready;
            word_prev  = {dout_last, dout};
        end
    end

    task automatic wait_done(input int target, input int budget, input bit rnd);
        int c;
        c = 0;
        while (done_cnt < target && c < budget) begin
            @(posedge clk);
            #1;
            if (rnd) dout_ready = 1'($urandom_range(0, 1));
            c++;
        end
        dout_ready = 1'b1;
        checks++;
        assert (done_cnt >= target)
        else begin
            failures++;
            $error("FAIL wait_done observed=%0d expected=%0d", done_cnt, target);
        end
    endtask

    task automatic wait_samp(input int k, input int budget);
        int c;
        c = 0;
        while (samp_in_pkt < k && c < budget) begin
            @(posedge clk);
            c++;
        end
        checks++;
        assert (samp_in_pkt >= k)
        else begin
            failures++;
            $error("FAIL wait_samp observed=%0d expected=%0d", samp_in_pkt, k);
        end
    endtask

    int p0;
    int r0;
    int d0;

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        check("reset_outputs", {busy, dout_valid, dout_last, dout, wvb_hdr_rdreq,
                                wvb_wvb_rdreq, wvb_wvb_rddone, n_wvf_sent}, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic packet.
        push_hdr(48'h0000_1234_5678, 15'd10, 15'd13, 2'd2, 1'b0);
        en = 1'b1;
        wait_done(1, 100, 1'b0);
        check("t1_drained", exp_q.size(), 0);
        check("t1_hdr_pops", pop_cnt, 1);
        check("t1_rdreqs", rdreq_cnt, 4);
        check("t1_sent", n_wvf_sent, 16'd1);

        // Address wrap.
        r0 = rdreq_cnt;
        push_hdr(48'hABCD_0000_0001, 15'd32765, 15'd2, 2'd1, 1'b1);
        wait_done(2, 100, 1'b0);
        check("t2_rdreqs", rdreq_cnt - r0, 6);
        check("t2_sent", n_wvf_sent, 16'd2);

        // Long waveform under random backpressure.
        push_hdr(48'h0000_0000_0100, 15'd100, 15'd355, 2'd3, 1'b0);
        wait_done(3, 3000, 1'b1);
        check("t3_drained", exp_q.size(), 0);
        check("t3_sent", n_wvf_sent, 16'd3);

        // Back-to-back queued headers, including a single-sample waveform.
        push_hdr(48'h1111_2222_3333, 15'd0, 15'd4, 2'd0, 1'b1);
        push_hdr(48'h4444_5555_6666, 15'd200, 15'd202, 2'd2, 1'b0);
        push_hdr(48'h7777_8888_9999, 15'd32767, 15'd32767, 2'd1, 1'b1);
        wait_done(6, 200, 1'b0);
        check("t4_drained", exp_q.size(), 0);
        check("t4_sent", n_wvf_sent, 16'd6);

        // Enable gating.
        en = 1'b0;
        p0 = pop_cnt;
        r0 = rdreq_cnt;
        push_hdr(48'h0000_AAAA_BBBB, 15'd50, 15'd59, 2'd0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("t5_no_pop", pop_cnt - p0, 0);
        check("t5_no_rdreq", rdreq_cnt - r0, 0);
        check("t5_idle", busy, 1'b0);
        en = 1'b1;
        wait_samp(2, 50);
        #1 en = 1'b0;
        wait_done(7, 100, 1'b0);
        check("t5_drained", exp_q.size(), 0);
        check("t5_sent", n_wvf_sent, 16'd7);
        push_hdr(48'h0000_CCCC_DDDD, 15'd5, 15'd7, 2'd3, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("t5_held", pop_cnt - p0, 1);
        en = 1'b1;
        wait_done(8, 100, 1'b0);
        check("t5_sent2", n_wvf_sent, 16'd8);

        // Reset in the middle of the sample stream.
        push_hdr(48'h0000_0F0F_F0F0, 15'd0, 15'd19, 2'd2, 1'b0);
        wait_samp(5, 100);
        d0 = done_cnt;
        #1 rst = 1'b1;
        #1;
        check("t6_reset_outputs", {busy, dout_valid, dout_last, dout, wvb_hdr_rdreq,
                                   wvb_wvb_rdreq, wvb_wvb_rddone, n_wvf_sent}, 64'h0);
        exp_q.delete();
        aborted++;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t6_no_rddone", done_cnt, d0);
        check("t6_idle", busy, 1'b0);
        push_hdr(48'h0000_0000_0042, 15'd300, 15'd304, 2'd1, 1'b0);
        wait_done(d0 + 1, 100, 1'b0);
        check("t6_drained", exp_q.size(), 0);
        check("t6_sent", n_wvf_sent, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
